// File: rtl/reg_transfer_seq_pkg.sv
// Shared definitions for the register-file transfer sequencer: FSM encoding,
// default bus geometry and the queued move-request layout.
package reg_xfer_pkg;

    localparam int NREG_DEF = 8;
    localparam int DW_DEF   = 16;
    localparam int FD_DEF   = 4;
    localparam int AW_DEF   = $clog2(NREG_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [AW_DEF-1:0] src;
        logic [AW_DEF-1:0] dst;
    } req_t;

endpackage

// File: rtl/reg_transfer_seq_if.sv
// Request handshake plus register-bank bus between the control unit (master)
// and the transfer sequencer (slave).
interface reg_transfer_seq_if
    import reg_xfer_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int DW   = DW_DEF
);
    localparam int AW = $clog2(NREG);

    logic            req_valid;
    logic            req_ready;
    logic [AW-1:0]   req_src;
    logic [AW-1:0]   req_dst;
    logic [NREG-1:0] t_en;
    logic [DW-1:0]   bus_in;
    logic [NREG-1:0] ld_en;
    logic [DW-1:0]   bus_out;
    logic            done;
    logic            busy;

    modport master (
        output req_valid, req_src, req_dst, bus_in,
        input  req_ready, t_en, ld_en, bus_out, done, busy
    );

    modport slave (
        input  req_valid, req_src, req_dst, bus_in,
        output req_ready, t_en, ld_en, bus_out, done, busy
    );
endinterface

// File: rtl/reg_transfer_seq_fifo.sv
// First-word-fall-through request FIFO; full/empty derive from the registered
// count so a push is refused whenever the FIFO was full at the start of the cycle.
module xfer_fifo #(
    parameter int W = 6,
    parameter int D = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(D):0]     count
);
    localparam int PW = $clog2(D);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_r [D];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == CW'(D));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Storage, pointers (wrap naturally since D is a power of 2) and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/reg_transfer_seq.sv
// Transfer sequencer: queues src->dst register moves and plays each one onto the
// shared bus as a DRIVE cycle (source enabled, bus captured) then a LOAD cycle.
module reg_transfer_seq
    import reg_xfer_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int DW   = DW_DEF,
    parameter int FD   = FD_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    reg_transfer_seq_if.slave  bus
);
    localparam int AW = $clog2(NREG);

    state_t          state_r;
    logic [AW-1:0]   dst_r;
    logic [DW-1:0]   hold_r;
    logic [NREG-1:0] t_en_r;
    logic [NREG-1:0] ld_en_r;
    logic            done_r;

    logic [2*AW-1:0]   head_s;
    logic [AW-1:0]     head_src_s;
    logic [AW-1:0]     head_dst_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              pop_s;
    logic [$clog2(FD):0] fifo_count_s;

    // Out-of-range indices yield an all-zero vector; the move still spends its two cycles.
    function automatic logic [NREG-1:0] decode(input logic [AW-1:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        if ({1'b0, idx} < (AW+1)'(NREG)) begin
            v[idx] = 1'b1;
        end else begin
            v = '0;
        end
        return v;
    endfunction

    xfer_fifo #(.W(2*AW), .D(FD)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.req_valid),
        .pop   (pop_s),
        .wdata ({bus.req_src, bus.req_dst}),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign head_src_s    = head_s[2*AW-1:AW];
    assign head_dst_s    = head_s[AW-1:0];
    assign pop_s         = ~fifo_empty_s & ((state_r == ST_IDLE) | (state_r == ST_LOAD));
    assign bus.req_ready = ~fifo_full_s;
    assign bus.busy      = (state_r != ST_IDLE) | (fifo_count_s != '0);
    assign bus.t_en      = t_en_r;
    assign bus.ld_en     = ld_en_r;
    assign bus.bus_out   = hold_r;
    assign bus.done      = done_r;

    // Move sequencer with registered enables, hold register and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            dst_r   <= '0;
            hold_r  <= '0;
            t_en_r  <= '0;
            ld_en_r <= '0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_LOAD: begin
                    ld_en_r <= '0;
                    done_r  <= 1'b0;
                    if (!fifo_empty_s) begin
                        dst_r   <= head_dst_s;
                        t_en_r  <= decode(head_src_s);
                        state_r <= ST_DRIVE;
                    end else begin
                        t_en_r  <= '0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_DRIVE: begin
                    t_en_r  <= '0;
                    ld_en_r <= decode(dst_r);
                    hold_r  <= bus.bus_in;
                    done_r  <= 1'b1;
                    state_r <= ST_LOAD;
                end
                default: begin
                    t_en_r  <= '0;
                    ld_en_r <= '0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
